// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive path: FSM states, field widths and
// frame timing constants.
package can_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_ID_A,
        S_RTR_SRR,
        S_IDE,
        S_ID_B,
        S_RTR,
        S_R1,
        S_R0,
        S_DLC,
        S_DATA,
        S_CRC,
        S_CRC_DEL,
        S_ACK_SLOT,
        S_ACK_DEL,
        S_EOF,
        S_INTERMISSION,
        S_ERROR
    } can_state_t;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    localparam int unsigned ID_A_W           = 11;
    localparam int unsigned ID_B_W           = 18;
    localparam int unsigned DLC_W            = 4;
    localparam int unsigned DATA_W           = 64;
    localparam int unsigned CRC_W            = 15;
    localparam int unsigned EOF_LEN          = 7;
    localparam int unsigned INTERMISSION_LEN = 3;
    localparam int unsigned ERROR_IDLE       = 11;
    localparam int unsigned STUFF_LIMIT      = 5;

    // Number of DATA bits carried by a frame; remote frames carry none.
    function automatic logic [6:0] data_bits(input logic [3:0] dlc, input logic rtr);
        if (rtr || dlc == 4'd0)
            return 7'd0;
        else if (dlc >= 4'd8)
            return 7'd64;
        else
            return {dlc[2:0], 3'b000};
    endfunction

endpackage

// File: rtl/can_destuffer.sv
// Bit-stuffing tracker: flags stuff bits to be dropped and stuff violations.
// Run length counts every received bit, stuff bits included.
module can_destuffer
    import can_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic bit_event,
    input  logic rx_bit,
    input  logic enable,
    input  logic restart,
    output logic data_valid,
    output logic stuff_error
);

    logic [2:0] run_len;
    logic       run_val;
    logic       stuff_slot;

    assign stuff_slot  = (run_len == 3'(STUFF_LIMIT));
    assign data_valid  = bit_event & ~(enable & stuff_slot);
    assign stuff_error = bit_event & enable & stuff_slot & (rx_bit == run_val);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_len <= '0;
            run_val <= 1'b1;
        end else if (bit_event) begin
            if (restart || (enable && (stuff_slot || rx_bit != run_val))) begin
                run_len <= 3'd1;
                run_val <= rx_bit;
            end else if (enable) begin
                run_len <= run_len + 3'd1;
            end
        end
    end

endmodule

// File: rtl/can_frame_decoder.sv
// CAN 2.0A/2.0B receive frame decoder: destuffs the sampled bit stream, walks
// the frame fields, holds every decoded field and checks CRC-15 and form.
module can_frame_decoder
    import can_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                rx_bit,
    input  logic                sample_point,
    output logic                field_start_of_frame,
    output logic [ID_A_W-1:0]   field_id_a,
    output logic                rtr_srr_temp,
    output logic                field_ide,
    output logic                field_rtr,
    output logic                field_srr,
    output logic                field_reserved1,
    output logic                field_reserved0,
    output logic [ID_B_W-1:0]   field_id_b,
    output logic [DLC_W-1:0]    field_dlc,
    output logic [DATA_W-1:0]   field_data,
    output logic [CRC_W-1:0]    field_crc,
    output logic                field_crc_delimiter,
    output logic                field_ack_slot,
    output logic                field_ack_delimiter,
    output logic                frame_done,
    output logic                crc_error,
    output logic                stuff_error,
    output logic                form_error
);

    can_state_t        state, state_d;
    logic [6:0]        cnt, cnt_d;
    logic              sp_q, bit_ev, dv, stuff_hit, destuff_en, crc_en, sof_hit;
    logic              done_d, crc_err_d, form_err_d, stuff_err_d, crc_fb;
    logic [CRC_W-1:0]  crc_reg, crc_next, crc_seq_next;
    logic [DLC_W-1:0]  dlc_next;
    logic [6:0]        data_len;

    assign bit_ev     = sample_point & ~sp_q;
    assign destuff_en = state inside {S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR, S_R1,
                                      S_R0, S_DLC, S_DATA, S_CRC};
    assign crc_en     = destuff_en && (state != S_CRC);
    // A dominant bit in INTERMISSION is taken as SOF rather than a form error.
    assign sof_hit    = bit_ev & ~rx_bit & ((state == S_IDLE) || (state == S_INTERMISSION));

    can_destuffer u_destuffer (
        .clock       (clock),
        .reset       (reset),
        .bit_event   (bit_ev),
        .rx_bit      (rx_bit),
        .enable      (destuff_en),
        .restart     (sof_hit),
        .data_valid  (dv),
        .stuff_error (stuff_hit)
    );

    assign crc_fb       = rx_bit ^ crc_reg[CRC_W-1];
    assign crc_next     = {crc_reg[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    assign crc_seq_next = {field_crc[CRC_W-2:0], rx_bit};
    assign dlc_next     = {field_dlc[DLC_W-2:0], rx_bit};
    assign data_len     = data_bits(field_dlc, field_rtr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            sp_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sp_q  <= sample_point;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        done_d      = 1'b0;
        crc_err_d   = 1'b0;
        form_err_d  = 1'b0;
        stuff_err_d = 1'b0;
        if (stuff_hit) begin
            stuff_err_d = 1'b1;
            state_d     = S_ERROR;
            cnt_d       = '0;
        end else if (dv) begin
            case (state)
                S_IDLE, S_INTERMISSION: begin
                    if (!rx_bit) begin
                        state_d = S_ID_A;
                        cnt_d   = '0;
                    end else if (state == S_INTERMISSION) begin
                        if (cnt == 7'(INTERMISSION_LEN - 1)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + 7'd1;
                        end
                    end
                end
                S_ID_A: begin
                    if (cnt == 7'(ID_A_W - 1)) begin
                        state_d = S_RTR_SRR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_RTR_SRR: state_d = S_IDE;
                S_IDE:     state_d = rx_bit ? S_ID_B : S_R0;
                S_ID_B: begin
                    if (cnt == 7'(ID_B_W - 1)) begin
                        state_d = S_RTR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_RTR: state_d = S_R1;
                S_R1:  state_d = S_R0;
                S_R0:  state_d = S_DLC;
                S_DLC: begin
                    if (cnt == 7'(DLC_W - 1)) begin
                        state_d = (data_bits(dlc_next, field_rtr) == 7'd0) ? S_CRC : S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == data_len - 7'd1) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_CRC: begin
                    if (cnt == 7'(CRC_W - 1)) begin
                        cnt_d = '0;
                        if (crc_seq_next != crc_reg) begin
                            crc_err_d = 1'b1;
                            state_d   = S_ERROR;
                        end else begin
                            state_d = S_CRC_DEL;
                        end
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_CRC_DEL, S_ACK_DEL: begin
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        state_d    = S_ERROR;
                        cnt_d      = '0;
                    end else begin
                        state_d = (state == S_CRC_DEL) ? S_ACK_SLOT : S_EOF;
                    end
                end
                S_ACK_SLOT: state_d = S_ACK_DEL;
                S_EOF: begin
                    if (!rx_bit) begin
                        form_err_d = 1'b1;
                        state_d    = S_ERROR;
                        cnt_d      = '0;
                    end else if (cnt == 7'(EOF_LEN - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_INTERMISSION;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                S_ERROR: begin
                    if (!rx_bit) begin
                        cnt_d = '0;
                    end else if (cnt == 7'(ERROR_IDLE - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            field_start_of_frame <= 1'b0;
            field_id_a           <= '0;
            rtr_srr_temp         <= 1'b0;
            field_ide            <= 1'b0;
            field_rtr            <= 1'b0;
            field_srr            <= 1'b0;
            field_reserved1      <= 1'b0;
            field_reserved0      <= 1'b0;
            field_id_b           <= '0;
            field_dlc            <= '0;
            field_data           <= '0;
            field_crc            <= '0;
            field_crc_delimiter  <= 1'b0;
            field_ack_slot       <= 1'b0;
            field_ack_delimiter  <= 1'b0;
            crc_reg              <= '0;
            frame_done           <= 1'b0;
            crc_error            <= 1'b0;
            stuff_error          <= 1'b0;
            form_error           <= 1'b0;
        end else begin
            frame_done  <= done_d;
            crc_error   <= crc_err_d;
            stuff_error <= stuff_err_d;
            form_error  <= form_err_d;
            if (sof_hit) begin
                field_start_of_frame <= rx_bit;
                field_id_a           <= '0;
                rtr_srr_temp         <= 1'b0;
                field_ide            <= 1'b0;
                field_rtr            <= 1'b0;
                field_srr            <= 1'b0;
                field_reserved1      <= 1'b0;
                field_reserved0      <= 1'b0;
                field_id_b           <= '0;
                field_dlc            <= '0;
                field_data           <= '0;
                field_crc            <= '0;
                field_crc_delimiter  <= 1'b0;
                field_ack_slot       <= 1'b0;
                field_ack_delimiter  <= 1'b0;
                crc_reg              <= '0;
            end else if (dv) begin
                if (crc_en)
                    crc_reg <= crc_next;
                case (state)
                    S_ID_A:    field_id_a <= {field_id_a[ID_A_W-2:0], rx_bit};
                    S_RTR_SRR: rtr_srr_temp <= rx_bit;
                    S_IDE: begin
                        field_ide <= rx_bit;
                        if (rx_bit)
                            field_srr <= rtr_srr_temp;
                        else
                            field_rtr <= rtr_srr_temp;
                    end
                    S_ID_B:     field_id_b <= {field_id_b[ID_B_W-2:0], rx_bit};
                    S_RTR:      field_rtr <= rx_bit;
                    S_R1:       field_reserved1 <= rx_bit;
                    S_R0:       field_reserved0 <= rx_bit;
                    S_DLC:      field_dlc <= dlc_next;
                    S_DATA:     field_data <= {field_data[DATA_W-2:0], rx_bit};
                    S_CRC:      field_crc <= crc_seq_next;
                    S_CRC_DEL:  field_crc_delimiter <= rx_bit;
                    S_ACK_SLOT: field_ack_slot <= rx_bit;
                    S_ACK_DEL:  field_ack_delimiter <= rx_bit;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_frame_decoder.sv
// Scoreboard bench for can_frame_decoder: frames are serialised with stuffing
// and CRC by the bench, expected events are queued and checked by a monitor.
module tb_can_frame_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_bit = 1'b1;
    logic        sample_point = 1'b0;
    logic        field_start_of_frame, rtr_srr_temp, field_ide, field_rtr, field_srr;
    logic        field_reserved1, field_reserved0;
    logic [10:0] field_id_a;
    logic [17:0] field_id_b;
    logic [3:0]  field_dlc;
    logic [63:0] field_data;
    logic [14:0] field_crc;
    logic        field_crc_delimiter, field_ack_slot, field_ack_delimiter;
    logic        frame_done, crc_error, stuff_error, form_error;

    can_frame_decoder dut (
        .clock                (clock),
        .reset                (reset),
        .rx_bit               (rx_bit),
        .sample_point         (sample_point),
        .field_start_of_frame (field_start_of_frame),
        .field_id_a           (field_id_a),
        .rtr_srr_temp         (rtr_srr_temp),
        .field_ide            (field_ide),
        .field_rtr            (field_rtr),
        .field_srr            (field_srr),
        .field_reserved1      (field_reserved1),
        .field_reserved0      (field_reserved0),
        .field_id_b           (field_id_b),
        .field_dlc            (field_dlc),
        .field_data           (field_data),
        .field_crc            (field_crc),
        .field_crc_delimiter  (field_crc_delimiter),
        .field_ack_slot       (field_ack_slot),
        .field_ack_delimiter  (field_ack_delimiter),
        .frame_done           (frame_done),
        .crc_error            (crc_error),
        .stuff_error          (stuff_error),
        .form_error           (form_error)
    );

    always #5 clock = ~clock;

    localparam logic [3:0] K_DONE  = 4'b1000;
    localparam logic [3:0] K_CRC   = 4'b0100;
    localparam logic [3:0] K_STUFF = 4'b0010;
    localparam logic [3:0] K_FORM  = 4'b0001;

    typedef struct {
        logic [3:0]  kind;
        logic [10:0] id_a;
        logic [17:0] id_b;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [14:0] crc;
    } exp_t;

    exp_t sb[$];
    bit   tx[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clock);
        rx_bit = b;
        sample_point = 1'b1;
        repeat (2) @(negedge clock);
        sample_point = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_tx(input int nbits);
        for (int i = 0; i < nbits && i < tx.size(); i++) send_bit(tx[i]);
    endtask

    task automatic build_frame(input logic [10:0] id_a, input logic ide, input logic [17:0] id_b,
                               input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                               input int crc_flip, input int eof_bad, input int imiss,
                               output logic [14:0] crc_tx);
        bit          raw[$];
        logic [14:0] c;
        int          nbits, run;
        bit          last, fb;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id_a[i]);
        if (!ide) begin
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end else begin
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id_b[i]);
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbits = (rtr || dlc == 4'd0) ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
        for (int i = nbits - 1; i >= 0; i--) raw.push_back(data[i]);
        c = '0;
        foreach (raw[i]) begin
            fb = raw[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
        crc_tx = c;
        for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
        tx.delete();
        run  = 0;
        last = 1'b1;
        for (int i = 0; i < raw.size(); i++) begin
            tx.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin
                run  = 1;
                last = raw[i];
            end
            if (run == 5 && i < raw.size() - 1) begin
                tx.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        tx.push_back(1'b1);
        tx.push_back(1'b0);
        tx.push_back(1'b1);
        for (int i = 0; i < 7; i++) tx.push_back(i == eof_bad ? 1'b0 : 1'b1);
        for (int i = 0; i < imiss; i++) tx.push_back(1'b1);
    endtask

    task automatic run_frame(input logic [10:0] id_a, input logic ide, input logic [17:0] id_b,
                             input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                             input logic [63:0] exp_data, input int crc_flip, input int eof_bad,
                             input int imiss, input logic [3:0] kind);
        exp_t e;
        logic [14:0] c;
        build_frame(id_a, ide, id_b, rtr, dlc, data, crc_flip, eof_bad, imiss, c);
        e.kind = kind;
        e.id_a = id_a;
        e.id_b = ide ? id_b : 18'd0;
        e.ide  = ide;
        e.rtr  = rtr;
        e.dlc  = dlc;
        e.data = exp_data;
        e.crc  = c;
        sb.push_back(e);
        send_tx(tx.size());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_id_a"}, 64'(field_id_a), 64'd0);
        chk({tag, "_id_b"}, 64'(field_id_b), 64'd0);
        chk({tag, "_dlc"},  64'(field_dlc), 64'd0);
        chk({tag, "_data"}, field_data, 64'd0);
        chk({tag, "_crc"},  64'(field_crc), 64'd0);
        chk({tag, "_bits"}, 64'({field_start_of_frame, rtr_srr_temp, field_ide, field_rtr,
                                 field_srr, field_reserved1, field_reserved0, field_crc_delimiter,
                                 field_ack_slot, field_ack_delimiter}), 64'd0);
        chk({tag, "_pulses"}, 64'({frame_done, crc_error, stuff_error, form_error}), 64'd0);
    endtask

    logic [3:0] got;
    exp_t       em;

    always @(negedge clock) begin
        if (reset) begin
            got = {frame_done, crc_error, stuff_error, form_error};
            if (got != 4'd0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %b expected none", got);
                end else begin
                    em = sb.pop_front();
                    chk("event_kind", 64'(got), 64'(em.kind));
                    if (em.kind == K_DONE && got == K_DONE) begin
                        chk("sof",       64'(field_start_of_frame), 64'd0);
                        chk("id_a",      64'(field_id_a), 64'(em.id_a));
                        chk("id_b",      64'(field_id_b), 64'(em.id_b));
                        chk("ide",       64'(field_ide), 64'(em.ide));
                        chk("rtr",       64'(field_rtr), 64'(em.rtr));
                        chk("srr",       64'(field_srr), 64'(em.ide));
                        chk("rtr_srr",   64'(rtr_srr_temp), 64'(em.ide ? 1'b1 : em.rtr));
                        chk("reserved",  64'({field_reserved1, field_reserved0}), 64'd0);
                        chk("dlc",       64'(field_dlc), 64'(em.dlc));
                        chk("data",      field_data, em.data);
                        chk("crc",       64'(field_crc), 64'(em.crc));
                        chk("delim_ack", 64'({field_crc_delimiter, field_ack_slot,
                                              field_ack_delimiter}), 64'b101);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        send_idle(3);

        // standard data frame, 8 bytes
        run_frame(11'h672, 1'b0, 18'd0, 1'b0, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'hAAAA_AAAA_AAAA_AAAA, -1, -1, 3, K_DONE);
        send_idle(2);
        // extended frame, 2 bytes
        run_frame(11'h123, 1'b1, 18'h2ABCD, 1'b0, 4'd2, 64'h55AA, 64'h55AA, -1, -1, 3, K_DONE);
        send_idle(2);
        // remote frame: DLC 8 but no data bits follow
        run_frame(11'h672, 1'b0, 18'd0, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, -1, -1, 3, K_DONE);
        send_idle(2);
        // DLC above 8 still carries 8 bytes
        run_frame(11'h001, 1'b0, 18'd0, 1'b0, 4'hF, 64'h0123_4567_89AB_CDEF,
                  64'h0123_4567_89AB_CDEF, -1, -1, 3, K_DONE);
        send_idle(2);
        // DLC 0, then next frame starts inside intermission
        run_frame(11'h555, 1'b0, 18'd0, 1'b0, 4'd0, 64'd0, 64'd0, -1, -1, 2, K_DONE);
        run_frame(11'h0F0, 1'b0, 18'd0, 1'b0, 4'd1, 64'h3C, 64'h3C, -1, -1, 3, K_DONE);
        send_idle(2);

        // six dominant bits after SOF
        em.kind = K_STUFF;
        sb.push_back(em);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_idle(11);
        run_frame(11'h7F0, 1'b0, 18'd0, 1'b0, 4'd1, 64'h81, 64'h81, -1, -1, 3, K_DONE);
        send_idle(2);

        // corrupted CRC bit
        run_frame(11'h672, 1'b0, 18'd0, 1'b0, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'hAAAA_AAAA_AAAA_AAAA, 4, -1, 3, K_CRC);
        send_idle(11);
        // dominant EOF bit
        run_frame(11'h2A5, 1'b0, 18'd0, 1'b0, 4'd1, 64'h5A, 64'h5A, -1, 3, 3, K_FORM);
        send_idle(11);

        // reset in the middle of DATA
        begin
            logic [14:0] c;
            build_frame(11'h672, 1'b0, 18'd0, 1'b0, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA, -1, -1, 3, c);
        end
        send_tx(30);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b1;
        send_idle(2);
        run_frame(11'h672, 1'b0, 18'd0, 1'b0, 4'd8, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'hAAAA_AAAA_AAAA_AAAA, -1, -1, 3, K_DONE);
        send_idle(4);

        repeat (20) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
